// File: rtl/wiegand_tx_if.sv
// Host-side bundle for the Wiegand-26 transmitter: frame request/data in,
// progress flags and the two active-low data lines out.
interface wiegand_tx_if #(
    parameter int NBITS = 26
);
    logic             start;
    logic [NBITS-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [1:0]       wil_out;

    modport master (
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  wil_out
    );

    modport slave (
        input  start,
        input  tx_data,
        output busy,
        output done,
        output wil_out
    );
endinterface

// File: rtl/wiegand_tx.sv
// Wiegand-26 transmitter: pulses D0/D1 low per bit, MSB first, then a quiet guard gap.
// Optional PARITY_GEN_EN wraps the payload with leading even / trailing odd parity bits.
module wiegand_tx #(
    parameter int NBITS      = 26,
    parameter int PULSE_CYC  = 100,
    parameter int PERIOD_CYC = 1000,
    parameter int GUARD_CYC  = 6000
) (
    input logic        clk,
    input logic        nCPLDCE,
    wiegand_tx_if.slave bus
);

    localparam int          IW         = $clog2(NBITS);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] SPACE_LAST = 16'(PERIOD_CYC - PULSE_CYC - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SPACE,
        GUARD
    } state_t;

    state_t           state;
    logic [15:0]      cyc_cnt;
    logic [NBITS-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic [NBITS-1:0] frame;

    // A '1' pulls D1 (bit 1) low, a '0' pulls D0 (bit 0) low; never both.
    function automatic logic [1:0] line_low(input logic b);
        return b ? 2'b01 : 2'b10;
    endfunction

`ifdef PARITY_GEN_EN
    localparam int PW = NBITS - 2;
    localparam int LW = PW / 2;

    always_comb begin
        frame = {^bus.tx_data[PW-1:LW], bus.tx_data[PW-1:0], ~^bus.tx_data[LW-1:0]};
    end
`else
    always_comb begin
        frame = bus.tx_data;
    end
`endif

    always_ff @(posedge clk or negedge nCPLDCE) begin
        if (!nCPLDCE) begin
            state       <= IDLE;
            cyc_cnt     <= 16'd0;
            shreg       <= '0;
            bit_idx     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.wil_out <= 2'b11;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg       <= frame;
                        bit_idx     <= IW'(NBITS - 1);
                        cyc_cnt     <= 16'd0;
                        bus.busy    <= 1'b1;
                        bus.wil_out <= line_low(frame[NBITS-1]);
                        state       <= PULSE;
                    end
                end
                PULSE: begin
                    if (cyc_cnt == PULSE_LAST) begin
                        cyc_cnt     <= 16'd0;
                        bus.wil_out <= 2'b11;
                        state       <= SPACE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                // The next bit's falling edge lands exactly one bit period after the previous one.
                SPACE: begin
                    if (cyc_cnt == SPACE_LAST) begin
                        cyc_cnt <= 16'd0;
                        if (bit_idx != '0) begin
                            shreg       <= shreg << 1;
                            bit_idx     <= bit_idx - 1'b1;
                            bus.wil_out <= line_low(shreg[NBITS-2]);
                            state       <= PULSE;
                        end else begin
                            state <= GUARD;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                GUARD: begin
                    if (cyc_cnt == GUARD_LAST) begin
                        cyc_cnt  <= 16'd0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wiegand_tx.sv
// Directed bench for wiegand_tx with shortened timing so several full frames fit the run.
// Build with +define+PARITY_GEN_EN to exercise parity framing as well.
module tb_wiegand_tx;

    localparam int NBITS      = 26;
    localparam int PULSE_CYC  = 5;
    localparam int PERIOD_CYC = 12;
    localparam int GUARD_CYC  = 30;
    localparam int FRAME_END  = NBITS * PERIOD_CYC + GUARD_CYC;

    logic clk     = 1'b0;
    logic nCPLDCE = 1'b0;
    int   checks  = 0;
    int   passes  = 0;

    wiegand_tx_if #(.NBITS(NBITS)) bus();

    wiegand_tx #(
        .NBITS(NBITS),
        .PULSE_CYC(PULSE_CYC),
        .PERIOD_CYC(PERIOD_CYC),
        .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk(clk),
        .nCPLDCE(nCPLDCE),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NBITS-1:0] build_frame(input logic [NBITS-1:0] tx);
`ifdef PARITY_GEN_EN
        logic [NBITS-3:0] p;
        p = tx[NBITS-3:0];
        return {^p[NBITS-3:(NBITS-2)/2], p, ~^p[(NBITS-2)/2-1:0]};
`else
        return tx;
`endif
    endfunction

    // Expected {wil_out, busy, done} t cycles after the accepting edge.
    function automatic logic [3:0] model(input logic [NBITS-1:0] f, input int t);
        logic b;
        if (t < NBITS * PERIOD_CYC) begin
            b = f[NBITS-1-(t/PERIOD_CYC)];
            if ((t % PERIOD_CYC) < PULSE_CYC)
                return {(b ? 2'b01 : 2'b10), 2'b10};
            return 4'b1110;
        end
        if (t < FRAME_END)  return 4'b1110;
        if (t == FRAME_END) return 4'b1101;
        return 4'b1100;
    endfunction

    task automatic start_frame(input logic [NBITS-1:0] tx);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = tx;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = NBITS'($urandom());
    endtask

    task automatic test_reset;
        nCPLDCE     = 1'b0;
        bus.start   = 1'b1;
        bus.tx_data = 26'h3FFFFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== 4'b1100)
                $display("[TB] FAIL reset_hold: got %b expected 1100", {bus.wil_out, bus.busy, bus.done});
            else passes++;
        end
        bus.start = 1'b0;
        nCPLDCE   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== 4'b1100)
                $display("[TB] FAIL reset_release_idle: got %b expected 1100", {bus.wil_out, bus.busy, bus.done});
            else passes++;
        end
    endtask

    task automatic test_alternating;
        logic [NBITS-1:0] f;
        logic [3:0]       exp;
        logic [1:0]       hand;
        f = build_frame(26'h2AAAAAA);
        start_frame(26'h2AAAAAA);
        for (int t = 0; t <= FRAME_END + 2; t++) begin
            exp = model(f, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL alternating t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
`ifndef PARITY_GEN_EN
            if (t == 0 || t == PULSE_CYC - 1 || t == PULSE_CYC || t == PERIOD_CYC) begin
                hand = (t == PERIOD_CYC) ? 2'b10 : ((t == PULSE_CYC) ? 2'b11 : 2'b01);
                checks++;
                if (bus.wil_out !== hand)
                    $display("[TB] FAIL alternating_edge t=%0d: got %b expected %b", t, bus.wil_out, hand);
                else passes++;
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_loopback(input logic [NBITS-1:0] tx, input logic [NBITS-1:0] exp_frame);
        logic [NBITS-1:0] rx;
        logic [1:0]       prev;
        int               nrx;
        int               ndone;
        rx = '0; prev = 2'b11; nrx = 0; ndone = 0;
        start_frame(tx);
        checks++;
        if (bus.wil_out !== (exp_frame[NBITS-1] ? 2'b01 : 2'b10))
            $display("[TB] FAIL loopback_first_line: got %b expected first bit %b", bus.wil_out, exp_frame[NBITS-1]);
        else passes++;
        for (int t = 0; t <= FRAME_END + 2; t++) begin
            if (prev == 2'b11 && bus.wil_out != 2'b11) begin
                rx = {rx[NBITS-2:0], (bus.wil_out == 2'b01)};
                nrx++;
            end
            prev = bus.wil_out;
            if (bus.done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (rx !== exp_frame) $display("[TB] FAIL loopback_data: got %h expected %h", rx, exp_frame);
        else passes++;
        checks++;
        if (nrx != NBITS) $display("[TB] FAIL loopback_pulses: got %0d expected %0d", nrx, NBITS);
        else passes++;
        checks++;
        if (ndone != 1) $display("[TB] FAIL loopback_done: got %0d expected 1", ndone);
        else passes++;
    endtask

    task automatic test_busy_ignore;
        logic [NBITS-1:0] f;
        logic [3:0]       exp;
        int               ndone;
        ndone = 0;
        f = build_frame(26'h155AA33);
        start_frame(26'h155AA33);
        for (int t = 0; t <= FRAME_END + 3; t++) begin
            exp = model(f, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL busy_ignore t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
            if (bus.done) ndone++;
            if (t == 5 * PERIOD_CYC || t == FRAME_END - 1) begin
                bus.start   = 1'b1;
                bus.tx_data = 26'h3FFFFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 1) $display("[TB] FAIL busy_ignore_done: got %0d expected 1", ndone);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [NBITS-1:0] f;
        logic [3:0]       exp;
        int               ndone;
        localparam int CUT = 12 * PERIOD_CYC + 2;
        f = build_frame(26'h0F0F0F1);
        start_frame(26'h0F0F0F1);
        for (int t = 0; t <= CUT; t++) begin
            exp = model(f, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL pre_reset t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
            if (t != CUT) @(negedge clk);
        end
        #2 nCPLDCE = 1'b0;
        #1;
        checks++;
        if ({bus.wil_out, bus.busy, bus.done} !== 4'b1100)
            $display("[TB] FAIL async_reset: got %b expected 1100", {bus.wil_out, bus.busy, bus.done});
        else passes++;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        nCPLDCE = 1'b1;
        repeat (FRAME_END) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        checks++;
        if (ndone != 0) $display("[TB] FAIL reset_no_done: got %0d expected 0", ndone);
        else passes++;
        f = build_frame(26'h2C3A5F0);
        start_frame(26'h2C3A5F0);
        for (int t = 0; t <= FRAME_END + 1; t++) begin
            exp = model(f, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL post_reset t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [NBITS-1:0] fa;
        logic [NBITS-1:0] fb;
        logic [3:0]       exp;
        fa = build_frame(26'h1234567);
        fb = build_frame(26'h2FEDCBA);
        start_frame(26'h1234567);
        for (int t = 0; t <= FRAME_END; t++) begin
            exp = model(fa, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL b2b_first t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
            if (t == FRAME_END) begin
                bus.start   = 1'b1;
                bus.tx_data = 26'h2FEDCBA;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int t = 0; t <= FRAME_END + 1; t++) begin
            exp = model(fb, t);
            checks++;
            if ({bus.wil_out, bus.busy, bus.done} !== exp)
                $display("[TB] FAIL b2b_second t=%0d: got %b expected %b", t, {bus.wil_out, bus.busy, bus.done}, exp);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
        test_reset();
        test_alternating();
`ifdef PARITY_GEN_EN
        test_loopback({2'b11, 24'hFFF000}, {1'b0, 24'hFFF000, 1'b1});
`else
        test_loopback(26'h3000001, 26'h3000001);
`endif
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
